// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   localparam int          PC_STEP     = 4;
   localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

endpackage : pc_pkg

// File: rtl/pc_if.sv
// Bundle between the PC stage and its downstream control/fetch block.
// Handshake: there is no valid/ready pair. The downstream block samples PC
// whenever fetch_valid=1. It returns PCsrc/ImmOp as combinational functions
// of that PC. The PC stage consumes them on every rising edge where en=1 in RUN.
// The state member exposes the FSM state for observation only.
interface pc_if
   import pc_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
);
   logic                     en;
   logic                     PCsrc;
   logic [DATA_WIDTH-1:0]    ImmOp;
   logic [ADDRESS_WIDTH-1:0] PC;
   logic [ADDRESS_WIDTH-1:0] PCplus4;
   logic                     fetch_valid;
   logic                     halted;
   logic [15:0]              retired;
   pc_state_t                state;

   // Driven by the downstream block / testbench.
   modport master (
      output en, PCsrc, ImmOp,
      input  PC, PCplus4, fetch_valid, halted, retired, state
   );

   // Driven by pc_unit.
   modport slave (
      input  en, PCsrc, ImmOp,
      output PC, PCplus4, fetch_valid, halted, retired, state
   );
endinterface : pc_if

// File: rtl/pc_next.sv
// Combinational next-PC arithmetic: sequential step, branch target, and
// detection of a branch onto itself. All sums wrap modulo 2^ADDRESS_WIDTH.
module pc_next
   import pc_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic [ADDRESS_WIDTH-1:0] pc_i,
   input  logic                     pcsrc_i,
   input  logic [DATA_WIDTH-1:0]    imm_i,
   output logic [ADDRESS_WIDTH-1:0] next_pc_o,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
   output logic                     self_branch_o
);
   // Only the low address bits of the offset matter. Misaligned offsets pass through.
   logic [ADDRESS_WIDTH-1:0] imm_lo;
   logic [ADDRESS_WIDTH-1:0] target;

   assign imm_lo = imm_i[ADDRESS_WIDTH-1:0];

   // Step and branch adders plus the next-PC select.
   always_comb begin
      pc_plus4_o    = pc_i + ADDRESS_WIDTH'(PC_STEP);
      target        = pc_i + imm_lo;
      next_pc_o     = pcsrc_i ? target : pc_plus4_o;
      self_branch_o = pcsrc_i && (imm_lo == '0);
   end
endmodule : pc_next

// File: rtl/pc_unit.sv
// Program-counter stage. It holds the PC, sequences BOOT -> RUN -> HALT,
// counts retired advances, and halts after repeated self-branches.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                   ADDRESS_WIDTH = 8,
   parameter int                   DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0,
   parameter int                   HALT_COUNT    = 4
) (
   input  logic clk,
   input  logic rst,
   pc_if.slave  bus
);
   localparam int CNT_W = (HALT_COUNT < 2) ? 1 : $clog2(HALT_COUNT + 1);

   pc_state_t                state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]         loop_q, loop_d;
   logic [15:0]              retired_q, retired_d;

   logic [ADDRESS_WIDTH-1:0] next_pc;
   logic [ADDRESS_WIDTH-1:0] pc_plus4;
   logic                     self_branch;
   logic [CNT_W-1:0]         loop_inc;

   pc_next #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_pc_next (
      .pc_i          (pc_q),
      .pcsrc_i       (bus.PCsrc),
      .imm_i         (bus.ImmOp),
      .next_pc_o     (next_pc),
      .pc_plus4_o    (pc_plus4),
      .self_branch_o (self_branch)
   );

   assign loop_inc = loop_q + CNT_W'(1);

   // State, PC, loop counter and retired counter registers with async reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         loop_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         loop_q    <= loop_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic. Stalls and HALT keep every register as it is.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      loop_d    = loop_q;
      retired_d = retired_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (bus.en) begin
               pc_d = next_pc;
               if (retired_q != RETIRED_MAX) retired_d = retired_q + 16'd1;
               if (self_branch) begin
                  loop_d = loop_inc;
                  if (loop_inc == CNT_W'(HALT_COUNT)) state_d = HALT;
               end else begin
                  loop_d = '0;
               end
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   // Registered PC plus outputs decoded from the registered state.
   always_comb begin
      bus.PC          = pc_q;
      bus.PCplus4     = pc_plus4;
      bus.fetch_valid = (state_q == RUN);
      bus.halted      = (state_q == HALT);
      bus.retired     = retired_q;
      bus.state       = state_q;
   end
endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with a behavioural reference model.
module tb_pc_unit;
   import pc_pkg::*;

   localparam int AW         = 8;
   localparam int DW         = 32;
   localparam int HALT_COUNT = 4;

   logic clk;
   logic rst;

   pc_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   pc_unit #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .RESET_PC      (8'h00),
      .HALT_COUNT    (HALT_COUNT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. phase: 0 = booting, 1 = running, 2 = halted.
   int m_pc, m_ret, m_loop, m_phase;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc    <= 0;
         m_ret   <= 0;
         m_loop  <= 0;
         m_phase <= 0;
      end else if (m_phase == 0) begin
         m_phase <= 1;
      end else if (m_phase == 1 && bus.en) begin
         m_pc  <= bus.PCsrc ? (m_pc + int'(bus.ImmOp % 256)) % 256 : (m_pc + 4) % 256;
         m_ret <= (m_ret < 65535) ? m_ret + 1 : m_ret;
         if (bus.PCsrc && (bus.ImmOp % 256) == 0) begin
            m_loop <= m_loop + 1;
            if (m_loop + 1 == HALT_COUNT) m_phase <= 2;
         end else begin
            m_loop <= 0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare of DUT outputs against the model, on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         check("model_pc",      int'(bus.PC),          m_pc);
         check("model_pcplus4", int'(bus.PCplus4),     (m_pc + 4) % 256);
         check("model_fvalid",  int'(bus.fetch_valid), (m_phase == 1) ? 1 : 0);
         check("model_halted",  int'(bus.halted),      (m_phase == 2) ? 1 : 0);
         check("model_retired", int'(bus.retired),     m_ret);
      end
   end

   // driver: apply inputs for one cycle, then land 1 time unit past the edge
   task automatic cycle(input logic e, input logic s, input logic [DW-1:0] imm);
      bus.en    = e;
      bus.PCsrc = s;
      bus.ImmOp = imm;
      @(posedge clk);
      #1;
   endtask

   // Hand-computed literal expectations.
   task automatic lit(input string name, input int pc, input int fv, input int hl, input int ret);
      check({name, "_pc"},      int'(bus.PC),          pc);
      check({name, "_fvalid"},  int'(bus.fetch_valid), fv);
      check({name, "_halted"},  int'(bus.halted),      hl);
      check({name, "_retired"}, int'(bus.retired),     ret);
   endtask

   initial begin
      rst       = 1'b0;
      bus.en    = 1'b1;
      bus.PCsrc = 1'b0;
      bus.ImmOp = '0;
      @(posedge clk); #1;
      started = 1;
      @(posedge clk); #1;
      lit("in_reset", 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      lit("boot", 0, 0, 0, 0);
      // BOOT leaves on the next edge even with en=0
      cycle(1'b0, 1'b0, 32'h0);
      lit("first_run", 0, 1, 0, 0);
      cycle(1'b1, 1'b0, 32'h0); lit("seq1", 32'h04, 1, 0, 1);
      cycle(1'b1, 1'b0, 32'h0); lit("seq2", 32'h08, 1, 0, 2);
      cycle(1'b1, 1'b0, 32'h0); lit("seq3", 32'h0C, 1, 0, 3);
      cycle(1'b1, 1'b0, 32'h0); lit("seq4", 32'h10, 1, 0, 4);
      // backward and forward branches
      cycle(1'b1, 1'b1, 32'hFFFF_FFF8); lit("br_back", 32'h08, 1, 0, 5);
      cycle(1'b1, 1'b1, 32'h0000_0020); lit("br_fwd",  32'h28, 1, 0, 6);
      cycle(1'b1, 1'b1, 32'h0000_00D4); lit("to_fc",   32'hFC, 1, 0, 7);
      check("pcplus4_wrap", int'(bus.PCplus4), 32'h00);
      // wrap-around
      cycle(1'b1, 1'b0, 32'h0);         lit("wrap_seq", 32'h00, 1, 0, 8);
      cycle(1'b1, 1'b1, 32'h0000_00F8); lit("to_f8",    32'hF8, 1, 0, 9);
      cycle(1'b1, 1'b1, 32'h0000_0010); lit("wrap_br",  32'h08, 1, 0, 10);
      cycle(1'b1, 1'b1, 32'h0000_000C); lit("to_14",    32'h14, 1, 0, 11);
      // stall for five cycles; upper ImmOp bits set to check they are ignored
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h1234_5600);
      lit("stall", 32'h14, 1, 0, 11);
      cycle(1'b1, 1'b0, 32'h0); lit("unstall", 32'h18, 1, 0, 12);
      // three self-branches (one with upper bits set), then a normal advance
      cycle(1'b1, 1'b1, 32'h0000_0000);
      cycle(1'b1, 1'b1, 32'h0000_0100);
      cycle(1'b1, 1'b1, 32'h0000_0000);
      lit("self3", 32'h18, 1, 0, 15);
      cycle(1'b1, 1'b0, 32'h0); lit("break", 32'h1C, 1, 0, 16);
      // a stalled self-branch does not count toward the loop
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h0);
      cycle(1'b0, 1'b1, 32'h0);
      lit("self3b", 32'h1C, 1, 0, 19);
      cycle(1'b1, 1'b1, 32'h0);
      lit("halt", 32'h1C, 0, 1, 20);
      check("state_halt", int'(bus.state), int'(HALT));
      // HALT ignores every input
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
      lit("halt_hold", 32'h1C, 0, 1, 20);
      check("halt_pcplus4", int'(bus.PCplus4), 32'h20);
      // reset from HALT, then run up to 0x40
      rst = 1'b0;
      #1;
      lit("rst_halt", 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      cycle(1'b1, 1'b0, 32'h0); lit("reboot", 0, 1, 0, 0);
      cycle(1'b1, 1'b1, 32'h40); lit("at_40", 32'h40, 1, 0, 1);
      // asynchronous reset in the middle of a RUN cycle
      #3;
      rst = 1'b0;
      #1;
      lit("async_rst", 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      lit("boot2", 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 32'h0); lit("run2", 0, 1, 0, 0);
      cycle(1'b1, 1'b0, 32'h0); lit("run2_seq", 32'h04, 1, 0, 1);
      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule : tb_pc_unit

// File: doc/pc_unit.md
# pc_unit

Program-counter stage directly upstream of the control/fetch block. It holds the architectural PC, computes the next PC from the branch decision (`PCsrc`) and immediate (`ImmOp`) returned by the downstream block, and sequences boot, stall and halt. It also reports fetch validity and a retired-instruction count to the testbench and top level.

## Interface

- `ADDRESS_WIDTH`, 8: PC / instruction-memory address width.
- `DATA_WIDTH`, 32: width of `ImmOp`.
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_COUNT`, 4: consecutive self-branches that trigger halt (≥1).

Ports:

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low (0 = reset).
- `en`  in  1  advance enable; 0 = stall (hold all state).
- `PCsrc`  in  1  branch taken, from downstream control.
- `ImmOp`  in  DATA_WIDTH  sign-extended branch offset, from downstream.
- `PC`  out  ADDRESS_WIDTH  current fetch address (registered).
- `PCplus4`  out  ADDRESS_WIDTH  `PC + 4`, combinational, mod 2^ADDRESS_WIDTH.
- `fetch_valid`  out  1  current `PC` is a live fetch.
- `halted`  out  1  core halted.
- `retired`  out  16  count of PC advances, saturating.

## Operation

- States: `BOOT`, `RUN`, `HALT`.
- Reset (`rst`=0, asynchronous): state=`BOOT`, `PC`=`RESET_PC`, loop counter=0, `retired`=0, `fetch_valid`=0, `halted`=0.
- `BOOT`: one cycle. On the next edge, go to `RUN` regardless of `en`. `PC` unchanged.
- `RUN`: `fetch_valid`=1.
  - Edge with `en`=1:
    - `PC` ← `PCsrc` ? `PC + ImmOp[ADDRESS_WIDTH-1:0]` : `PC + 4`.
    - Arithmetic is modulo 2^ADDRESS_WIDTH. Upper `ImmOp` bits are ignored.
    - Misaligned offsets are added as-is.
    - `retired` increments and saturates at 0xFFFF.
  - Edge with `en`=0: `PC`, `retired` and the loop counter all hold.
- Self-loop detection, on advancing edges only:
  - Self-branch = `PCsrc`=1 and `ImmOp[ADDRESS_WIDTH-1:0]`=0.
  - A self-branch increments the loop counter. Any other advance clears it.
  - On the edge where the counter would reach `HALT_COUNT`, go to `HALT`. That edge still counts in `retired`.
- `HALT`: `PC` frozen, `fetch_valid`=0, `halted`=1. `en`, `PCsrc` and `ImmOp` are ignored. Exit only via reset.
- Reset mid-operation: outputs take their reset values immediately, without waiting for an edge. Operation resumes with a fresh `BOOT` after `rst` deasserts.

## Timing

- `PC` changes only on a rising `clk` edge (or asynchronously on reset).
- `PCsrc`/`ImmOp` are combinational functions of the current `PC` in the downstream block. They are sampled on the same edge that updates `PC`.
- Redirect latency: a branch decided in cycle n gives the target `PC` in cycle n+1. There is no bubble and no delay slot.
- First live fetch: the cycle after `rst` deasserts plus one edge (the `BOOT` cycle).
- `PCplus4` is valid in every state, including `HALT`.
- Halt visibility: `halted`=1 in the cycle after the `HALT_COUNT`-th self-branch edge.
- `en` has no effect in `BOOT` or `HALT`.

## Structure

- Shared package `pc_pkg`:
  - `typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t`.
  - `localparam PC_STEP = 4`.
  - `localparam RETIRED_MAX = 16'hFFFF`.
- Sub-module `pc_next`:
  - Combinational.
  - Inputs: `PC`, `PCsrc`, `ImmOp`.
  - Outputs: next PC, `PCplus4`, self-branch flag.
- `pc_unit` holds the state register, the PC register, the loop counter and the `retired` counter.

## Test plan

- Reset then release → `PC`=0x00, `fetch_valid`=0 for 1 cycle, then 1; with `en`=1 and `PCsrc`=0, `PC` = 0x04, 0x08, 0x0C on successive cycles; `retired`=3.
- At `PC`=0x10, `PCsrc`=1, `ImmOp`=0xFFFFFFF8 → next `PC`=0x08; at 0x08, `ImmOp`=0x00000020 → 0x28.
- Wrap-around: at `PC`=0xFC, `PCsrc`=0 → `PC`=0x00; at 0xF8, `ImmOp`=0x10 → 0x08.
- `en`=0 for 5 cycles at `PC`=0x14 → `PC` stays 0x14 and `retired` unchanged; `en`=1 → 0x18.
- Self-branch with `HALT_COUNT`=4:
  - Three self-branches, one normal advance, then four self-branches → no halt after the first three.
  - `halted`=1 and `fetch_valid`=0 the cycle after the 4th consecutive self-branch.
  - `PC` frozen thereafter, even with `PCsrc`=0 and `en`=1.
- Assert `rst`=0 mid-cycle while in `RUN` at `PC`=0x40 → `PC`=0x00 and `retired`=0 before the next edge; `BOOT` repeats on release.
